// File: rtl/unix_time_decoder.sv
// unix_time_decoder: Unix seconds -> binary year/month/day/h/m/s fields.
// Optional weekday output is built when UNIX_TIME_DECODER_WEEKDAY_EN is defined.
module unix_time_decoder #(
  parameter int TIME_W     = 31,
  parameter int EPOCH_YEAR = 1970,
  parameter int EPOCH_WDAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [TIME_W-1:0] in_time,
  output logic              in_ready,
  output logic              out_valid,
  output logic [10:0]       out_year,
  output logic [3:0]        out_month,
  output logic [4:0]        out_day,
  output logic [4:0]        out_hour,
  output logic [5:0]        out_minute,
  output logic [5:0]        out_second,
  output logic [2:0]        out_weekday
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_HOUR, S_MIN, S_YEAR, S_MONTH, S_OUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [4:0]        cnt;
  logic [TIME_W-1:0] q;
  logic [17:0]       acc;
  logic [10:0]       year;
  logic [3:0]        month;
  logic [4:0]        hour;
  logic [5:0]        minute;

  logic              leap;
  logic [8:0]        ylen;
  logic [4:0]        mlen;
  logic [17:0]       rsh;
  logic              div_ge;
  logic [17:0]       dsr;
  logic              sub_ge;

  // Arithmetic helpers: year/month lengths and divider compare terms
  always_comb begin
    leap = (year[1:0] == 2'd0);
    ylen = leap ? 9'd366 : 9'd365;
    unique case (month)
      4'd2:                      mlen = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   mlen = 5'd30;
      default:                   mlen = 5'd31;
    endcase
    rsh    = {acc[16:0], q[TIME_W-1]};
    div_ge = (rsh >= 18'd86400);
    if (state == S_HOUR)
      dsr = 18'd3600 << (3'd4 - cnt[2:0]);
    else
      dsr = 18'd60 << (3'd5 - cnt[2:0]);
    sub_ge = (acc >= dsr);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_DIV;
      S_DIV:   if (cnt == 5'd30) state_nxt = S_HOUR;
      S_HOUR:  if (cnt == 5'd4) state_nxt = S_MIN;
      S_MIN:   if (cnt == 5'd5) state_nxt = S_YEAR;
      S_YEAR:  if (q < TIME_W'(ylen)) state_nxt = S_MONTH;
      S_MONTH: if (q < TIME_W'(mlen)) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake output
  always_comb begin
    in_ready = (state == S_IDLE);
  end

  // Datapath: long division, then year/month peeling on the day count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      q      <= '0;
      acc    <= '0;
      year   <= '0;
      month  <= '0;
      hour   <= '0;
      minute <= '0;
    end else begin
      cnt <= (state_nxt != state) ? 5'd0 : cnt + 5'd1;
      case (state)
        S_IDLE: if (in_valid) begin
          q     <= in_time;
          acc   <= '0;
          year  <= 11'(EPOCH_YEAR);
          month <= 4'd1;
        end
        S_DIV: begin
          acc <= div_ge ? rsh - 18'd86400 : rsh;
          q   <= {q[TIME_W-2:0], div_ge};
        end
        S_HOUR: begin
          if (sub_ge) acc <= acc - dsr;
          hour <= {hour[3:0], sub_ge};
        end
        S_MIN: begin
          if (sub_ge) acc <= acc - dsr;
          minute <= {minute[4:0], sub_ge};
        end
        S_YEAR: if (q >= TIME_W'(ylen)) begin
          q    <= q - TIME_W'(ylen);
          year <= year + 11'd1;
        end
        S_MONTH: if (q >= TIME_W'(mlen)) begin
          q     <= q - TIME_W'(mlen);
          month <= month + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef UNIX_TIME_DECODER_WEEKDAY_EN
  logic [2:0] wr;
  logic [3:0] wr2;
  logic [2:0] wr_nxt;
  logic [3:0] wsum;
  logic [2:0] wd;

  // Running day-count mod 7 and weekday offset from the epoch
  always_comb begin
    wr2    = {wr, div_ge};
    wr_nxt = 3'(wr2 >= 4'd7 ? wr2 - 4'd7 : wr2);
    wsum   = {1'b0, wr} + 4'(EPOCH_WDAY);
    wd     = 3'(wsum >= 4'd7 ? wsum - 4'd7 : wsum);
  end

  // Mod-7 accumulator tracks quotient bits as they emerge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           wr <= '0;
    else if (state == S_IDLE)          wr <= '0;
    else if (state == S_DIV)           wr <= wr_nxt;
  end
`else
  logic unused_wday;
  assign unused_wday = ^EPOCH_WDAY;
`endif

  // Result registers: loaded once per transaction, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_year    <= '0;
      out_month   <= '0;
      out_day     <= '0;
      out_hour    <= '0;
      out_minute  <= '0;
      out_second  <= '0;
      out_weekday <= '0;
    end else begin
      out_valid <= (state == S_OUT);
      if (state == S_OUT) begin
        out_year   <= year;
        out_month  <= month;
        out_day    <= q[4:0] + 5'd1;
        out_hour   <= hour;
        out_minute <= minute;
        out_second <= acc[5:0];
`ifdef UNIX_TIME_DECODER_WEEKDAY_EN
        out_weekday <= wd;
`else
        out_weekday <= 3'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_unix_time_decoder.sv
// tb_unix_time_decoder: directed + random checks of unix_time_decoder
// against a calendar-arithmetic reference model.
module tb_unix_time_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [30:0] in_time;
  logic        in_ready;
  logic        out_valid;
  logic [10:0] out_year;
  logic [3:0]  out_month;
  logic [4:0]  out_day;
  logic [4:0]  out_hour;
  logic [5:0]  out_minute;
  logic [5:0]  out_second;
  logic [2:0]  out_weekday;

  int checks = 0;
  int errors = 0;

  unix_time_decoder dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_time(in_time),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_year(out_year),
    .out_month(out_month),
    .out_day(out_day),
    .out_hour(out_hour),
    .out_minute(out_minute),
    .out_second(out_second),
    .out_weekday(out_weekday)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic void model(input longint t,
                                output int y, output int mo,
                                output int d, output int h,
                                output int mi, output int s,
                                output int wd);
    int ml [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    longint days;
    longint sod;
    int len;
    days = t / 86400;
    sod  = t % 86400;
    h    = int'(sod / 3600);
    mi   = int'((sod % 3600) / 60);
    s    = int'(sod % 60);
    wd   = int'((days + 4) % 7);
    y = 1970;
    len = is_leap(y) ? 366 : 365;
    while (days >= len) begin
      days -= len;
      y++;
      len = is_leap(y) ? 366 : 365;
    end
    mo = 1;
    len = ml[0];
    while (days >= len) begin
      days -= len;
      mo++;
      len = ml[mo-1] + ((mo == 2 && is_leap(y)) ? 1 : 0);
    end
    d = int'(days) + 1;
  endfunction

  task automatic xact(input logic [30:0] t, input int poke);
    int ey, emo, ed, eh, emi, es, ew, lat, n;
    model(longint'(t), ey, emo, ed, eh, emi, es, ew);
`ifndef UNIX_TIME_DECODER_WEEKDAY_EN
    ew = 0;
`endif
    lat = 44 + (ey - 1970) + emo;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_time  = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_time  = '0;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    chk("out_valid_low", 32'(out_valid), 32'd0);
    n = 0;
    while (n < 150 && !out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n == poke) begin
        in_valid = 1'b1;
        in_time  = 31'd12345;
      end else if (n == poke + 1) begin
        in_valid = 1'b0;
        in_time  = '0;
      end
    end
    chk("latency", 32'(n), 32'(lat));
    chk("year", 32'(out_year), 32'(ey));
    chk("month", 32'(out_month), 32'(emo));
    chk("day", 32'(out_day), 32'(ed));
    chk("hour", 32'(out_hour), 32'(eh));
    chk("minute", 32'(out_minute), 32'(emi));
    chk("second", 32'(out_second), 32'(es));
    chk("weekday", 32'(out_weekday), 32'(ew));
  endtask

  initial begin
    int pulses;
    logic [30:0] r;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_time  = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_year", 32'(out_year), 32'd0);
    chk("rst_month", 32'(out_month), 32'd0);
    chk("rst_day", 32'(out_day), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    xact(31'd0, -1);
    xact(31'd86399, -1);
    xact(31'd86400, -1);
    xact(31'd951782400, -1);
    xact(31'd1704067199, -1);
    xact(31'd1704067200, -1);
    xact(31'd2147483647, -1);

    @(negedge clk);
    in_valid = 1'b1;
    in_time  = 31'd1704067199;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_year", 32'(out_year), 32'd0);
    chk("abort_hour", 32'(out_hour), 32'd0);
    chk("abort_second", 32'(out_second), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (130) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);

    xact(31'd0, -1);
    xact(31'd1704067199, 10);

    repeat (12) begin
      r = 31'($urandom());
      xact(r, -1);
    end
    repeat (4) begin
      r = 31'($urandom_range(0, 400)) * 31'd86400
        + 31'($urandom_range(0, 3)) * 31'd86399;
      xact(r, 5);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unix_time_decoder.md
Name: unix_time_decoder

Overview:
- Sequential front end of the UnixTime converter datapath.
- Accepts a 31-bit Unix timestamp (seconds since 1970-01-01 00:00:00 UTC).
- Produces binary calendar and time-of-day fields: year, month, day, hour, minute, second and weekday.
- Its outputs feed the downstream binary-to-BCD stage, one field per converter instance.

Parameters:
- TIME_W, 31, timestamp width. Only 31 is supported; the range is 1970-01-01 to 2038-01-19 03:14:07.
- EPOCH_YEAR, 1970, binary year that corresponds to day 0.
- EPOCH_WDAY, 4, weekday of day 0, encoded 0=Sunday..6=Saturday.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  timestamp strobe; sampled only while in_ready=1
- in_time  in  TIME_W  Unix seconds
- in_ready  out  1  high in IDLE only
- out_valid  out  1  one-cycle result pulse
- out_year  out  11  binary year, 1970..2038
- out_month  out  4  1..12
- out_day  out  5  1..31
- out_hour  out  5  0..23
- out_minute  out  6  0..59
- out_second  out  6  0..59
- out_weekday  out  3  0..6; see Optional Feature

Behaviour:
- Reset (async assert):
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - All field outputs and internal registers are 0.
  - Deassertion is synchronous to clk.
- Reset mid-operation: aborts immediately; no out_valid pulse follows. The next transaction starts clean.
- FSM states: IDLE -> DIV -> HOUR -> MIN -> YEAR -> MONTH -> OUT -> IDLE.
- IDLE:
  - in_valid=1 at a clock edge latches in_time and enters DIV.
  - in_valid while not IDLE is ignored. There is no queue.
- DIV, 31 cycles:
  - Restoring division of in_time by 86400, one quotient bit per cycle, MSB first.
  - 18-bit partial remainder.
  - Results: days (15 bits), sod = seconds of day (17 bits).
- HOUR, 5 cycles: restoring division of sod by 3600, producing hour (5 bits) and remainder r1 (12 bits).
- MIN, 6 cycles: restoring division of r1 by 60, producing minute and second.
- YEAR:
  - Each cycle computes len = 366 if year[1:0]==0, else 365. This leap rule is exact over 1970..2038.
  - If days >= len: days -= len and year++. Otherwise go to MONTH.
  - Takes Y+1 cycles, where Y = year-EPOCH_YEAR.
- MONTH:
  - Uses the standard month-length table; February is 29 days in leap years.
  - Each cycle: if days >= len(month), subtract and month++. Otherwise go to OUT.
  - month starts at 1; takes M cycles, where M = final month.
- OUT:
  - Loads all field outputs with day = days+1.
  - Pulses out_valid for exactly one cycle, then returns to IDLE.
- Latency: out_valid is high in the cycle after the (44+Y+M)-th rising edge following the accepting edge. Minimum 45, maximum 113.
- Output holding:
  - Field outputs are registered and hold the last result until the next OUT.
  - They do not change during a computation.
- Throughput: a new in_valid may be accepted in the cycle after out_valid, when in_ready=1 again.
- All arithmetic is unsigned. No input value inside TIME_W bits can overflow any field.

Optional Feature:
- Macro: UNIX_TIME_DECODER_WEEKDAY_EN.
- Defined:
  - During DIV, a mod-7 accumulator tracks the quotient: wr = (2*wr + qbit) mod 7 each cycle.
  - In OUT, out_weekday = (wr + EPOCH_WDAY) mod 7.
  - Latency is unchanged.
- Undefined: no accumulator logic; out_weekday is tied to 0.

Test Plan:
- in_time=0 -> 1970/01/01 00:00:00, weekday 4, out_valid 45 edges after accept.
- in_time=86399 -> 1970/01/01 23:59:59, weekday 4; then 86400 back-to-back -> 1970/01/02 00:00:00, weekday 5.
- in_time=951782400 -> 2000/02/29 00:00:00, weekday 2, latency 76 (leap-day path).
- in_time=1704067199 -> 2023/12/31 23:59:59, weekday 0; next 1704067200 -> 2024/01/01 00:00:00, weekday 1.
- in_time=2147483647 -> 2038/01/19 03:14:07, weekday 2, latency 113 (maximum).
- Reset and busy handling:
  - Accept 1704067199, assert rst at cycle 20 -> in_ready=1, out_valid never pulses, outputs 0.
  - Then accept 0 -> correct result.
  - in_valid pulsed with 12345 during DIV -> ignored, and the original result is unchanged.
